// File: rtl/mmio_io_responder.sv
// I/O page responder: switch/button reads, LED and seven-segment writes,
// plus the synchronisers, button debouncer and digit scanner behind them.
module mmio_io_responder #(
   parameter int SW_W     = 16,
   parameter int LED_W    = 16,
   parameter int DEB_CNT  = 1000000,
   parameter int SCAN_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ior,
   input  logic             iow,
   input  logic [9:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [SW_W-1:0]  sw_in,
   input  logic             btn_in,
   output logic [LED_W-1:0] led_out,
   output logic [7:0]       seg_an,
   output logic [7:0]       seg_cat
);

   localparam int DEB_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   localparam logic [7:0] SEL_SW   = 8'h00;
   localparam logic [7:0] SEL_BTN  = 8'h01;
   localparam logic [7:0] SEL_LED  = 8'h04;
   localparam logic [7:0] SEL_SEGD = 8'h08;
   localparam logic [7:0] SEL_SEGE = 8'h09;

   logic [7:0]        sel;
   logic [SW_W-1:0]   sw_s1, sw_s2;
   logic              btn_s1, btn_sync, btn_stable, sticky;
   logic [DEB_W-1:0]  deb_cnt;
   logic [31:0]       seg_data;
   logic [7:0]        seg_en;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        digit;
   logic              deb_accept, btn_rise, rd_clr;
   logic [3:0]        nibble;
   logic [7:0]        an_next, cat_next, hex_pat;
   logic              unused_bits;

   assign sel         = addr[9:2];
   assign unused_bits = ^addr[1:0];

   // Debouncer accepts the new level on the last counted cycle of a persistent difference.
   assign deb_accept = (btn_sync != btn_stable) && (deb_cnt == DEB_LAST);
   assign btn_rise   = deb_accept && btn_sync;
   assign rd_clr     = ior && (sel == SEL_BTN);

   always_comb begin
      rdata = '0;
      if (ior) begin
         case (sel)
            SEL_SW:  rdata = 32'(sw_s2);
            SEL_BTN: rdata = {30'b0, sticky, btn_stable};
            default: rdata = '0;
         endcase
      end
   end

   always_comb begin
      nibble = seg_data[{digit, 2'b00} +: 4];
      case (nibble)
         4'h0: hex_pat = 8'hC0;
         4'h1: hex_pat = 8'hF9;
         4'h2: hex_pat = 8'hA4;
         4'h3: hex_pat = 8'hB0;
         4'h4: hex_pat = 8'h99;
         4'h5: hex_pat = 8'h92;
         4'h6: hex_pat = 8'h82;
         4'h7: hex_pat = 8'hF8;
         4'h8: hex_pat = 8'h80;
         4'h9: hex_pat = 8'h90;
         4'hA: hex_pat = 8'h88;
         4'hB: hex_pat = 8'h83;
         4'hC: hex_pat = 8'hC6;
         4'hD: hex_pat = 8'hA1;
         4'hE: hex_pat = 8'h86;
         default: hex_pat = 8'h8E;
      endcase
      an_next  = 8'hFF;
      cat_next = 8'hFF;
      if (seg_en[digit]) begin
         an_next  = ~(8'h01 << digit);
         cat_next = hex_pat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1    <= '0;
         sw_s2    <= '0;
         btn_s1   <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         sw_s1    <= sw_in;
         sw_s2    <= sw_s1;
         btn_s1   <= btn_in;
         btn_sync <= btn_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt    <= '0;
         btn_stable <= 1'b0;
         sticky     <= 1'b0;
      end else begin
         if (btn_sync == btn_stable) begin
            deb_cnt <= '0;
         end else if (deb_accept) begin
            btn_stable <= btn_sync;
            deb_cnt    <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
         // A new press outranks a simultaneous read-to-clear.
         if (btn_rise)
            sticky <= 1'b1;
         else if (rd_clr)
            sticky <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_out  <= '0;
         seg_data <= '0;
         seg_en   <= '0;
      end else if (iow) begin
         case (sel)
            SEL_LED:  led_out  <= wdata[LED_W-1:0];
            SEL_SEGD: seg_data <= wdata;
            SEL_SEGE: seg_en   <= wdata[7:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         digit    <= 3'd0;
         seg_an   <= 8'hFF;
         seg_cat  <= 8'hFF;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
         seg_an  <= an_next;
         seg_cat <= cat_next;
      end
   end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: register vector table, button debounce and
// sticky sequences, scanner sequence and reset-abandon sequence.
module tb_mmio_io_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ior = 1'b0;
   logic        iow = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [15:0] sw_in = '0;
   logic        btn_in = 1'b0;
   logic [15:0] led_out;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_q[$];

   mmio_io_responder #(.SW_W(16), .LED_W(16), .DEB_CNT(4), .SCAN_DIV(2)) dut (
      .clk(clk), .rst(rst), .ior(ior), .iow(iow), .addr(addr), .wdata(wdata),
      .rdata(rdata), .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out),
      .seg_an(seg_an), .seg_cat(seg_cat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        ior;
      logic        iow;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [15:0] sw;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;

   vec_t vecs[9];

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: got %h, scoreboard empty", nm, act);
         return;
      end
      e = exp_q.pop_front();
      if (act === e) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, e);
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] e, input string nm);
      @(negedge clk);
      ior  = 1'b1;
      addr = a;
      expect_val(e);
      #1 check(nm, rdata);
   endtask

   task automatic idle();
      @(negedge clk);
      ior = 1'b0;
      iow = 1'b0;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      iow   = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1 iow = 1'b0;
   endtask

   initial begin
      logic [7:0] prev;
      logic       found;
      logic [7:0] an_e, cat_e;

      vecs[0] = '{"led_wr",     1'b0, 1'b1, 10'h010, 32'h0000A5A5, 16'h1234, 32'h0,        16'hA5A5};
      vecs[1] = '{"sw_rd",      1'b1, 1'b0, 10'h000, 32'h0,        16'h1234, 32'h00001234, 16'hA5A5};
      vecs[2] = '{"unmap_rd",   1'b1, 1'b0, 10'h3FC, 32'h0,        16'h1234, 32'h0,        16'hA5A5};
      vecs[3] = '{"sw_rd_lsb",  1'b1, 1'b0, 10'h002, 32'h0,        16'hBEEF, 32'h0000BEEF, 16'hA5A5};
      vecs[4] = '{"led_rd",     1'b1, 1'b0, 10'h010, 32'h0,        16'hBEEF, 32'h0,        16'hA5A5};
      vecs[5] = '{"unmap_wr",   1'b0, 1'b1, 10'h3FC, 32'hFFFFFFFF, 16'hBEEF, 32'h0,        16'hA5A5};
      vecs[6] = '{"led_wr_lsb", 1'b0, 1'b1, 10'h011, 32'h12345A5A, 16'h0F00, 32'h0,        16'h5A5A};
      vecs[7] = '{"rd_and_wr",  1'b1, 1'b1, 10'h010, 32'h00000F0F, 16'h0F00, 32'h0,        16'h0F0F};
      vecs[8] = '{"btn_idle",   1'b1, 1'b0, 10'h004, 32'h0,        16'h0F00, 32'h0,        16'h0F0F};

      // Reset state
      repeat (3) @(negedge clk);
      expect_val(32'h0);  #1 check("rst_led", 32'(led_out));
      expect_val(32'hFF); check("rst_an", 32'(seg_an));
      expect_val(32'hFF); check("rst_cat", 32'(seg_cat));
      expect_val(32'h0);  check("rst_rdata", rdata);
      @(negedge clk);
      rst = 1'b0;

      // Register vector table
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         sw_in = vecs[i].sw;
         repeat (2) @(negedge clk);
         ior   = vecs[i].ior;
         iow   = vecs[i].iow;
         addr  = vecs[i].addr;
         wdata = vecs[i].wdata;
         expect_val(vecs[i].exp_rdata);
         #1 check({vecs[i].name, "_rdata"}, rdata);
         @(negedge clk);
         ior = 1'b0;
         iow = 1'b0;
         expect_val(32'(vecs[i].exp_led));
         #1 check({vecs[i].name, "_led"}, 32'(led_out));
      end

      // Short glitch is rejected
      @(negedge clk) btn_in = 1'b1;
      repeat (2) @(negedge clk);
      btn_in = 1'b0;
      repeat (10) @(negedge clk);
      rd(10'h004, 32'h0, "glitch_rd");
      idle();

      // Held press is accepted, sticky is read-to-clear
      @(negedge clk) btn_in = 1'b1;
      repeat (10) @(negedge clk);
      rd(10'h004, 32'h3, "press_rd1");
      rd(10'h004, 32'h1, "press_rd2");
      idle();

      // Release, then a press whose set edge coincides with a read-clear
      btn_in = 1'b0;
      repeat (10) @(negedge clk);
      rd(10'h004, 32'h0, "release_rd");
      idle();
      @(negedge clk) btn_in = 1'b1;
      repeat (5) @(negedge clk);
      ior  = 1'b1;
      addr = 10'h004;
      expect_val(32'h0);
      #1 check("coinc_before", rdata);
      @(negedge clk);
      expect_val(32'h3);
      #1 check("coinc_after", rdata);
      ior = 1'b0;
      rd(10'h004, 32'h3, "coinc_rd1");
      rd(10'h004, 32'h1, "coinc_rd2");
      idle();

      // Scanner: digits 0 and 1 enabled showing F and 3
      wr(10'h020, 32'h0000003F);
      wr(10'h024, 32'h00000003);
      repeat (16) @(negedge clk);
      prev  = seg_an;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (prev == 8'hFF && seg_an == 8'hFE) found = 1'b1;
         else prev = seg_an;
      end
      expect_val(32'h1);
      check("scan_sync", 32'(found));
      for (int j = 0; j < 17; j++) begin
         if (j > 0) @(negedge clk);
         if (j < 2 || j == 16) begin an_e = 8'hFE; cat_e = 8'h8E; end
         else if (j < 4) begin an_e = 8'hFD; cat_e = 8'hB0; end
         else begin an_e = 8'hFF; cat_e = 8'hFF; end
         expect_val(32'(an_e));
         expect_val(32'(cat_e));
         #1 check($sformatf("scan_an_%0d", j), 32'(seg_an));
         check($sformatf("scan_cat_%0d", j), 32'(seg_cat));
      end

      // Reset mid-scan while digit 0 is lit and LEDs are set
      @(negedge clk);
      rst = 1'b1;
      expect_val(32'h0);  #1 check("mid_rst_led", 32'(led_out));
      expect_val(32'hFF); check("mid_rst_an", 32'(seg_an));
      expect_val(32'hFF); check("mid_rst_cat", 32'(seg_cat));
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      iow   = 1'b1;
      addr  = 10'h024;
      wdata = 32'h000000FF;
      @(posedge clk);
      #1 iow = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         case (j)
            1: an_e = 8'hFF;
            2: an_e = 8'hFE;
            3, 4: an_e = 8'hFD;
            default: an_e = 8'hFB;
         endcase
         cat_e = (j == 1) ? 8'hFF : 8'hC0;
         expect_val(32'(an_e));
         expect_val(32'(cat_e));
         #1 check($sformatf("restart_an_%0d", j), 32'(seg_an));
         check($sformatf("restart_cat_%0d", j), 32'(seg_cat));
      end
      expect_val(32'h0);
      check("restart_led", 32'(led_out));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder for the 1 KB I/O page at 0xFFFFFC00–0xFFFFFFFF.
- Serves the CPU's `ior`/`iow` strobes: returns switch and button state on loads, and latches LED and seven-segment data on stores.
- Owns the board-facing sequential logic: switch and button synchronisers, a button debouncer with a sticky press flag, and the seven-segment digit scanner.
- Sits beside data memory; the top level muxes `rdata` onto the register write-back path when `ior` is high.

Parameters:
- SW_W, 16, number of board switches (1..32).
- LED_W, 16, number of board LEDs (1..32).
- DEB_CNT, 1000000, cycles a synchronised button level must persist before it is accepted.
- SCAN_DIV, 100000, clock cycles each seven-segment digit is held active.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- ior, input, 1, I/O read strobe (load to the I/O page).
- iow, input, 1, I/O write strobe (store to the I/O page).
- addr, input, 10, ALU result [9:0], the byte offset within the I/O page.
- wdata, input, 32, store data.
- rdata, output, 32, load data (combinational).
- sw_in, input, SW_W, raw asynchronous switches.
- btn_in, input, 1, raw asynchronous push button.
- led_out, output, LED_W, LED drive, active-high.
- seg_an, output, 8, digit anodes, active-low, one-hot.
- seg_cat, output, 8, cathodes {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Register selection uses addr[9:2]; addr[1:0] is ignored.
- Address map:
  - 0x000 R: switches, zero-extended to 32 bits.
  - 0x004 R: {30'b0, sticky, btn_stable}.
  - 0x010 W: LED register; takes wdata[LED_W-1:0].
  - 0x020 W: seg_data; 8 hex nibbles, digit i = wdata[4i+3:4i].
  - 0x024 W: seg_en; wdata[7:0], bit i enables digit i.
- Unmapped reads return 0, as do reads of 0x010/0x020/0x024. Unmapped writes are ignored. rdata = 0 whenever ior = 0.
- Writes take effect on the rising edge with iow = 1. A new value is visible on led_out the next cycle.
- Reads are combinational from registered state, so the value is valid in the same cycle ior is asserted.
- Switch path:
  - 2-FF synchroniser per bit.
  - The read returns the second-stage value, i.e. 2-cycle latency from sw_in.
- Button path, stage 1: 2-FF synchroniser produces btn_sync.
- Button path, stage 2: debouncer with counter deb_cnt.
  - If btn_sync == btn_stable: deb_cnt <= 0.
  - Otherwise deb_cnt increments.
  - When deb_cnt == DEB_CNT-1 and levels still differ: btn_stable <= btn_sync and deb_cnt <= 0.
  - Any bounce back to equality restarts the count.
- Sticky press flag:
  - Set on the cycle btn_stable transitions 0→1.
  - Cleared on the rising edge where ior = 1 and address 0x004 is selected (read-to-clear). rdata in that cycle still shows the pre-clear value.
  - If set and clear fall in the same edge, set wins.
- Seven-segment scanner:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index (3 bits) increments, wrapping 7→0.
- Seven-segment outputs:
  - seg_an = ~(1 << digit) when seg_en[digit] = 1, else 8'hFF.
  - seg_cat = active-low hex pattern of the current nibble when enabled, else 8'hFF; dp is always off.
  - Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - Outputs are registered: they reflect the digit and register state of the previous cycle.
- ior and iow together: handled independently; both actions occur.
- Reset (async, immediate) values:
  - led_out = 0, seg_data = 0, seg_en = 0.
  - seg_an = FF, seg_cat = FF.
  - scan_cnt = 0, digit = 0.
  - Synchronisers = 0, deb_cnt = 0, btn_stable = 0, sticky = 0.
- Reset asserted mid-debounce or mid-scan abandons the in-progress count; no stale state survives.

Test Plan:
- Reset, then one cycle of iow=1, addr=0x010, wdata=0x0000A5A5 → led_out=16'hA5A5 the following cycle; rdata=0 while ior=0.
- sw_in=16'h1234, wait 2 cycles, then ior=1, addr=0x000 → rdata=32'h00001234. Same read with addr=0x3FC → rdata=0.
- DEB_CNT=4, btn_in pulses high 2 cycles then low → btn_stable and sticky stay 0. btn_in held high ≥8 cycles → btn_stable=1 and sticky=1; read of 0x004 returns 3, a second read returns 1.
- Sticky set edge coinciding with a read-clear of 0x004 → sticky remains 1 after the edge.
- SCAN_DIV=2, seg_data=0x0000003F, seg_en=0x03 → anodes cycle FE→FD→FF(×6) every 2 cycles; digit0 cathodes=8E (F), digit1 cathodes=B0 (3).
- Assert rst mid-scan with LEDs set → led_out=0, seg_an=FF, seg_cat=FF immediately; after release, scanning restarts at digit 0.
